// File: rtl/alu_sequencer.sv
// Command-driven front end for the 8-bit combinational ALU: it fetches operands from a small
// register file, drives the ALU, writes the result back and returns it over a valid/ready channel.
module alu_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_sel,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carryout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LI  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_DIV = 4'b0011;

    localparam int unsigned DEPTH = 1 << AW;

    logic [1:0]        state;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [AW-1:0]     rd_q;
    logic              div_zero;
    logic [DATA_W-1:0] result;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // A zero divisor makes the ALU output meaningless; substitute all-ones and flag it.
    always_comb begin
        div_zero = (alu_sel == SEL_DIV) && (alu_b == '0);
        result   = div_zero ? '1 : alu_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b0;
                        case (cmd_op)
                            OP_ALU: begin
                                alu_a   <= regs[cmd_rs1];
                                alu_b   <= regs[cmd_rs2];
                                alu_sel <= cmd_sel;
                                rd_q    <= cmd_rd;
                                state   <= EXEC;
                            end
                            OP_LI: begin
                                regs[cmd_rd] <= cmd_imm;
                                rsp_data     <= cmd_imm;
                                state        <= RESP;
                            end
                            OP_RD: begin
                                rsp_data <= regs[cmd_rs1];
                                state    <= RESP;
                            end
                            default: begin
                                rsp_data <= '0;
                                state    <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    regs[rd_q] <= result;
                    rsp_data   <= result;
                    rsp_carry  <= (alu_sel == SEL_ADD) ? alu_carryout : 1'b0;
                    rsp_err    <= div_zero;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
